// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Two-port round-robin arbiter and sequencer in front of a small scratch RAM.
// The RAM has a combinational read and writes on the rising edge when its WR
// pin is high. This block owns the RAM address, write-data and WR pins. It
// serialises port A and port B accesses with a req/gnt handshake, and it
// returns read data to whichever port issued the read.
//
// After reset, and whenever clr_req is seen while idle, the block sweeps every
// RAM word and writes zero to it. Requests wait while the sweep runs.
//
// Parameters
//   AW  RAM address width. The depth is 2**AW and the sweep covers every word.
//   DW  RAM data width.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   clr_req    level request for a zero-fill sweep of the whole RAM
//   busy       high while sweeping; requests are held off meanwhile
//   req_x      port request; the requester holds it until gnt_x is seen
//   we_x       1 = write, 0 = read; held with req_x
//   addr_x     access address; held with req_x
//   wdata_x    write data; held with req_x
//   gnt_x      one-cycle grant; the RAM access takes place in this cycle
//   rdata_x    read data; holds its value until the same port's next read
//   rvalid_x   one-cycle pulse that marks rdata_x as fresh
//   ram_we     registered RAM WR
//   ram_addr   registered RAM address
//   ram_wdata  registered RAM write data
//   ram_rdata  RAM read data (combinational with respect to ram_addr)
//
// Every output is registered except busy, which is decoded from the state.
// -----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          gnt_a,
    output logic [DW-1:0] rdata_a,
    output logic          rvalid_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_b,
    output logic [DW-1:0] rdata_b,
    output logic          rvalid_b,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2
    } stateType;

    // The sweep counter is one bit wider than the address, so the compare
    // against the last word can never be hidden by a wrap to zero.
    localparam logic [AW:0] CNT_LAST = (AW + 1)'((2 ** AW) - 1);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    // Port indices: bit 0 is port A and bit 1 is port B.
    localparam logic PORT_B = 1'b1;

    stateType stateReg, stateNext;
    logic [AW:0]         cntReg, cntNext;
    logic                lastReg, lastNext;
    logic                ownerReg, ownerNext;
    logic [1:0]          gntReg, gntNext;
    logic [1:0]          rvalidReg, rvalidNext;
    logic [1:0][DW-1:0]  rdataReg, rdataNext;
    logic                ramWeReg, ramWeNext;
    logic [AW-1:0]       ramAddrReg, ramAddrNext;
    logic [DW-1:0]       ramWdataReg, ramWdataNext;

    // The two request ports are packed into vectors, so the winner can simply
    // index them.
    logic [1:0]          reqVec;
    logic [1:0]          weVec;
    logic [1:0][AW-1:0]  addrVec;
    logic [1:0][DW-1:0]  wdataVec;

    logic                grantNow;
    logic                winner;
    logic [1:0]          readReturn;

    assign reqVec   = {req_b, req_a};
    assign weVec    = {we_b, we_a};
    assign addrVec  = {addr_b, addr_a};
    assign wdataVec = {wdata_b, wdata_a};

    // A grant is issued from IDLE only when no clear is requested. clr_req
    // always takes priority over a pending port request.
    assign grantNow = (stateReg == IDLE) && !clr_req && (|reqVec);

    // A lone requester always wins. The round-robin pointer only breaks ties,
    // so a port can never be locked out by its own previous win.
    assign winner = (&reqVec) ? ~lastReg : reqVec[1];

    // Per-port grant and read-return logic. A read is returned to its owner
    // at the edge that closes the ACCESS cycle. At that point the RAM has
    // been presenting the latched address for a whole cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : gPort
        assign gntNext[gi]    = grantNow && (winner == (gi == 1));
        assign readReturn[gi] = (stateReg == ACCESS) && !ramWeReg
                                && (ownerReg == (gi == 1));
        assign rvalidNext[gi] = readReturn[gi];
        assign rdataNext[gi]  = readReturn[gi] ? ram_rdata : rdataReg[gi];
    end

    // Next-state logic and the registered RAM pin values.
    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        lastNext     = lastReg;
        ownerNext    = ownerReg;
        ramWeNext    = ramWeReg;
        ramAddrNext  = ramAddrReg;
        ramWdataNext = ramWdataReg;

        case (stateReg)
            CLEAR: begin
                // One zero write is queued per edge. The final write, to the
                // last word, reaches the RAM on the first edge in IDLE.
                ramWeNext    = 1'b1;
                ramAddrNext  = cntReg[AW-1:0];
                ramWdataNext = '0;
                cntNext      = cntReg + CNT_ONE;
                if (cntReg == CNT_LAST) begin
                    stateNext = IDLE;
                end
            end

            IDLE: begin
                if (clr_req) begin
                    stateNext = CLEAR;
                    cntNext   = '0;
                    ramWeNext = 1'b0;
                end else if (grantNow) begin
                    ramWeNext    = weVec[winner];
                    ramAddrNext  = addrVec[winner];
                    ramWdataNext = wdataVec[winner];
                    ownerNext    = winner;
                    lastNext     = winner;
                    stateNext    = ACCESS;
                end else begin
                    ramWeNext = 1'b0;
                end
            end

            ACCESS: begin
                // Every access lasts exactly one cycle. The block always
                // returns to IDLE, so two grants are never adjacent.
                ramWeNext = 1'b0;
                stateNext = IDLE;
            end

            default: begin
                stateNext = CLEAR;
                cntNext   = '0;
                ramWeNext = 1'b0;
            end
        endcase
    end

    // Reset aborts whatever is in flight. Grants and valids drop at once,
    // and the sweep starts again from word 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= CLEAR;
            cntReg      <= '0;
            lastReg     <= PORT_B;
            ownerReg    <= 1'b0;
            gntReg      <= '0;
            rvalidReg   <= '0;
            rdataReg    <= '0;
            ramWeReg    <= 1'b0;
            ramAddrReg  <= '0;
            ramWdataReg <= '0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            lastReg     <= lastNext;
            ownerReg    <= ownerNext;
            gntReg      <= gntNext;
            rvalidReg   <= rvalidNext;
            rdataReg    <= rdataNext;
            ramWeReg    <= ramWeNext;
            ramAddrReg  <= ramAddrNext;
            ramWdataReg <= ramWdataNext;
        end
    end

    assign busy      = (stateReg == CLEAR);
    assign gnt_a     = gntReg[0];
    assign gnt_b     = gntReg[1];
    assign rvalid_a  = rvalidReg[0];
    assign rvalid_b  = rvalidReg[1];
    assign rdata_a   = rdataReg[0];
    assign rdata_b   = rdataReg[1];
    assign ram_we    = ramWeReg;
    assign ram_addr  = ramAddrReg;
    assign ram_wdata = ramWdataReg;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Self-checking bench for ram_arbiter. It contains a behavioural 16x4 RAM
// (combinational read, write on the rising edge when WR is high), preloaded
// with nonzero contents. Each read that is issued pushes its expected data
// into a scoreboard queue. A negedge monitor pops one entry for every rvalid
// pulse and compares the port and the data. A table of single accesses is
// applied in a loop. Hand-written sequences cover round-robin, clear
// priority, asynchronous reset and the no-lockout case.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic          req_a = 1'b0, we_a = 1'b0;
    logic [AW-1:0] addr_a = '0;
    logic [DW-1:0] wdata_a = '0;
    logic          gnt_a, rvalid_a;
    logic [DW-1:0] rdata_a;
    logic          req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_b = '0;
    logic [DW-1:0] wdata_b = '0;
    logic          gnt_b, rvalid_b;
    logic [DW-1:0] rdata_b;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy),
        .req_a    (req_a),
        .we_a     (we_a),
        .addr_a   (addr_a),
        .wdata_a  (wdata_a),
        .gnt_a    (gnt_a),
        .rdata_a  (rdata_a),
        .rvalid_a (rvalid_a),
        .req_b    (req_b),
        .we_b     (we_b),
        .addr_b   (addr_b),
        .wdata_b  (wdata_b),
        .gnt_b    (gnt_b),
        .rdata_b  (rdata_b),
        .rvalid_b (rvalid_b),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Scratch RAM model. The preload is nonzero, so a missing sweep is
    // visible on later reads.
    logic [DW-1:0] mem [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h7};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    typedef struct packed {
        logic          port;   // 0 = A, 1 = B
        logic [DW-1:0] data;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdExp;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic port, input logic [DW-1:0] data);
        sb_t e;
        e.port = port;
        e.data = data;
        sbq.push_back(e);
    endtask

    // Monitor: every rvalid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rvalid_a || rvalid_b) begin
            sb_t e;
            check("rvalid_exclusive", 32'(rvalid_a && rvalid_b), 32'(0));
            check("sb_nonempty", 32'(sbq.size() != 0), 32'(1));
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("rvalid_port", 32'(rvalid_b), 32'(e.port));
                check("rdata", 32'(rvalid_b ? rdata_b : rdata_a), 32'(e.data));
            end
        end
    end

    // A single access from one port: request, grant one edge later, then
    // release. Reads are checked by the monitor.
    task automatic doAccess(input logic port, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [DW-1:0] rdExp);
        @(negedge clk);
        if (!port) begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
        end else begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
        end
        if (!we) pushExp(port, rdExp);
        $display("[TB] port %s %s addr %0h data %0h", port ? "B" : "A",
                 we ? "write" : "read", addr, we ? wdata : rdExp);
        @(negedge clk);
        check("gnt_latency", 32'({gnt_b, gnt_a}), port ? 32'(2) : 32'(1));
        check("ram_we", 32'(ram_we), 32'(we));
        check("ram_addr", 32'(ram_addr), 32'(addr));
        if (we) check("ram_wdata", 32'(ram_wdata), 32'(wdata));
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        check("gnt_drop", 32'({gnt_b, gnt_a}), 32'(0));
        check("ram_we_drop", 32'(ram_we), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busyCnt;
        int w;

        vecs[0] = '{1'b0, 1'b0, 4'd9, 4'h0, 4'h0};  // A read 9 after sweep
        vecs[1] = '{1'b0, 1'b1, 4'd3, 4'hA, 4'h0};  // A write 3 = A
        vecs[2] = '{1'b1, 1'b0, 4'd3, 4'h0, 4'hA};  // B read 3
        vecs[3] = '{1'b1, 1'b1, 4'd2, 4'h9, 4'h0};  // B write, B was last
        vecs[4] = '{1'b1, 1'b0, 4'd2, 4'h0, 4'h9};  // B again
        vecs[5] = '{1'b0, 1'b1, 4'd1, 4'h6, 4'h0};
        vecs[6] = '{1'b1, 1'b0, 4'd1, 4'h0, 4'h6};
        vecs[7] = '{1'b1, 1'b0, 4'd5, 4'h0, 4'h0};  // leaves last = B

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(1));
        check("reset_outputs", 32'({gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a,
                                    rdata_b, ram_we, ram_addr, ram_wdata}), 32'(0));

        // Power-up sweep: 16 busy cycles, zero written to words 0..15.
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("sweep_busy", 32'(busy), 32'(1));
            @(negedge clk);
            check("sweep_we", 32'(ram_we), 32'(1));
            check("sweep_addr", 32'(ram_addr), 32'(i));
            check("sweep_wdata", 32'(ram_wdata), 32'(0));
        end
        check("sweep_end_busy", 32'(busy), 32'(0));

        // Table of single accesses.
        for (int i = 0; i < 8; i++) begin
            doAccess(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                     vecs[i].rdExp);
        end

        // Both ports request continuously: A,B,A,B, two cycles apart.
        @(negedge clk);
        we_a = 1'b0; addr_a = 4'd1;
        we_b = 1'b0; addr_b = 4'd2;
        pushExp(1'b0, 4'h6); pushExp(1'b1, 4'h9);
        pushExp(1'b0, 4'h6); pushExp(1'b1, 4'h9);
        req_a = 1'b1; req_b = 1'b1;
        $display("[TB] both ports request continuously: reads A@1, B@2");
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("rr_gnt_a", 32'(gnt_a), 32'(k == 1 || k == 5));
            check("rr_gnt_b", 32'(gnt_b), 32'(k == 3 || k == 7));
            check("rr_mutex", 32'(gnt_a && gnt_b), 32'(0));
            if (k == 7) begin
                req_a = 1'b0; req_b = 1'b0;
            end
        end

        // clr_req and req_a in the same idle cycle: the clear wins.
        @(negedge clk);
        clr_req = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'd3;
        pushExp(1'b0, 4'h0);
        $display("[TB] clr_req with pending A read addr 3, expect 0");
        @(negedge clk);
        check("clr_beats_req", 32'(gnt_a), 32'(0));
        clr_req = 1'b0;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            busyCnt++;
            @(negedge clk);
        end
        check("clr_busy_cycles", 32'(busyCnt), 32'(16));
        for (w = 0; w < 4 && !gnt_a; w++) @(negedge clk);
        check("clr_then_gnt", 32'(gnt_a), 32'(1));
        req_a = 1'b0;
        @(negedge clk);
        doAccess(1'b0, 1'b0, 4'd1, 4'h0, 4'h0);
        doAccess(1'b1, 1'b0, 4'd2, 4'h0, 4'h0);

        // Asynchronous reset in the middle of a B read.
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'hC;
        $display("[TB] port B read addr c aborted by reset");
        @(negedge clk);
        check("abort_gnt_before", 32'(gnt_b), 32'(1));
        #2 rst = 1'b0;
        #1;
        check("abort_outputs", 32'({gnt_b, rvalid_b, ram_we}), 32'(0));
        check("abort_busy", 32'(busy), 32'(1));
        req_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_we", 32'(ram_we), 32'(1));
        check("restart_addr", 32'(ram_addr), 32'(0));
        for (w = 0; w < 40 && busy; w++) @(negedge clk);
        check("restart_done", 32'(busy), 32'(0));

        // Right after reset last = B; a lone B request must still be granted.
        doAccess(1'b1, 1'b0, 4'd4, 4'h0, 4'h0);
        doAccess(1'b1, 1'b0, 4'd7, 4'h0, 4'h0);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sbq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
